// File: rtl/call_stack_ctrl.sv
// ID-stage initiator for the register-file return stack: turns CALL/RET into
// push/pop pulses, tracks depth, captures the popped return PC and stalls ID.
module call_stack_ctrl #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ID_call,
    input  logic              ID_ret,
    input  logic [PC_W-1:0]   ID_pc,
    input  logic [DATA_W-1:0] ID_rd1,
    output logic              ID_push,
    output logic              ID_pop,
    output logic [PC_W-1:0]   stack_pc,
    output logic              ret_valid,
    output logic [PC_W-1:0]   ret_pc,
    output logic              stall,
    output logic [2:0]        depth,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              underflow,
    output logic              collision
);

    typedef enum logic [2:0] {IDLE, PUSH, POP, POP_WAIT, RET_OUT} state_t;

    state_t            state, state_nxt;
    logic [2:0]        depth_nxt;
    logic [PC_W-1:0]   stack_pc_nxt, ret_pc_nxt;
    logic              push_nxt, pop_nxt, ret_valid_nxt, stall_nxt;
    logic              overflow_nxt, underflow_nxt, collision_nxt;
    logic              rd1_unused;

    // Only the low PC_W bits of the popped word carry the return address.
    assign rd1_unused = ^ID_rd1[DATA_W-1:PC_W];

    assign full  = (depth == 3'(DEPTH));
    assign empty = (depth == 3'd0);

    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + {{(PC_W-1){1'b0}}, 1'b1};
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ID_push   <= 1'b0;
            ID_pop    <= 1'b0;
            stack_pc  <= '0;
            ret_valid <= 1'b0;
            ret_pc    <= '0;
            stall     <= 1'b0;
            depth     <= 3'd0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            collision <= 1'b0;
        end else begin
            state     <= state_nxt;
            ID_push   <= push_nxt;
            ID_pop    <= pop_nxt;
            stack_pc  <= stack_pc_nxt;
            ret_valid <= ret_valid_nxt;
            ret_pc    <= ret_pc_nxt;
            stall     <= stall_nxt;
            depth     <= depth_nxt;
            overflow  <= overflow_nxt;
            underflow <= underflow_nxt;
            collision <= collision_nxt;
        end
    end

    // Requests are only sampled in IDLE; upstream holds them while stalled.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ID_call) begin
                    state_nxt = full ? IDLE : PUSH;
                end else if (ID_ret && !empty) begin
                    state_nxt = POP;
                end
            end
            PUSH:     state_nxt = IDLE;
            POP:      state_nxt = POP_WAIT;
            POP_WAIT: state_nxt = RET_OUT;
            RET_OUT:  state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the upcoming state.
    always_comb begin
        depth_nxt     = depth;
        stack_pc_nxt  = stack_pc;
        ret_pc_nxt    = ret_pc;
        overflow_nxt  = overflow;
        underflow_nxt = underflow;
        collision_nxt = collision;
        case (state)
            IDLE: begin
                if (ID_call) begin
                    if (!full) begin
                        stack_pc_nxt = pc_inc(ID_pc);
                        depth_nxt    = depth + 3'd1;
                    end else begin
                        overflow_nxt = 1'b1;
                    end
                    if (ID_ret) begin
                        collision_nxt = 1'b1;
                    end
                end else if (ID_ret && empty) begin
                    underflow_nxt = 1'b1;
                end
            end
            POP:      depth_nxt  = depth - 3'd1;
            POP_WAIT: ret_pc_nxt = ID_rd1[PC_W-1:0];
            default: ;
        endcase
        push_nxt      = (state_nxt == PUSH);
        pop_nxt       = (state_nxt == POP);
        ret_valid_nxt = (state_nxt == RET_OUT);
        stall_nxt     = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Directed bench for call_stack_ctrl with hand-computed expectations.
module tb_call_stack_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        ID_call, ID_ret;
    logic [7:0]  ID_pc;
    logic [31:0] ID_rd1;
    logic        ID_push, ID_pop, ret_valid, stall, full, empty;
    logic        overflow, underflow, collision;
    logic [7:0]  stack_pc, ret_pc;
    logic [2:0]  depth;

    int compared   = 0;
    int mismatched = 0;

    call_stack_ctrl #(.DEPTH(4), .PC_W(8), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .ID_call(ID_call), .ID_ret(ID_ret),
        .ID_pc(ID_pc), .ID_rd1(ID_rd1), .ID_push(ID_push), .ID_pop(ID_pop),
        .stack_pc(stack_pc), .ret_valid(ret_valid), .ret_pc(ret_pc),
        .stall(stall), .depth(depth), .full(full), .empty(empty),
        .overflow(overflow), .underflow(underflow), .collision(collision)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] pushed [4];

    initial begin
        reset = 1'b0; ID_call = 1'b0; ID_ret = 1'b0; ID_pc = '0; ID_rd1 = '0;
        #3;
        chk("rst_push", ID_push, 0);   chk("rst_pop", ID_pop, 0);
        chk("rst_stall", stall, 0);    chk("rst_depth", depth, 0);
        chk("rst_empty", empty, 1);    chk("rst_full", full, 0);
        chk("rst_ovf", overflow, 0);   chk("rst_retv", ret_valid, 0);
        tick(); tick();
        reset = 1'b1;
        tick();

        // Single CALL then RET
        ID_call = 1'b1; ID_pc = 8'h10;
        tick();
        chk("call_push", ID_push, 1);  chk("call_spc", stack_pc, 8'h11);
        chk("call_depth", depth, 1);   chk("call_stall", stall, 1);
        ID_call = 1'b0;
        tick();
        chk("call_push_end", ID_push, 0); chk("call_stall_end", stall, 0);

        ID_ret = 1'b1; ID_rd1 = 32'h0000_0011;
        tick();
        chk("ret_pop", ID_pop, 1);     chk("ret_e0_depth", depth, 1);
        chk("ret_e0_rv", ret_valid, 0);
        ID_ret = 1'b0;
        tick();
        chk("ret_pop_end", ID_pop, 0); chk("ret_e1_depth", depth, 0);
        chk("ret_e1_rv", ret_valid, 0); chk("ret_e1_stall", stall, 1);
        tick();
        chk("ret_rv", ret_valid, 1);   chk("ret_pc", ret_pc, 8'h11);
        tick();
        chk("ret_rv_end", ret_valid, 0); chk("ret_stall_end", stall, 0);
        chk("ret_pc_hold", ret_pc, 8'h11);

        // Fill the stack, with PC wrap on the last CALL
        pushed[0] = 8'h21; pushed[1] = 8'h31; pushed[2] = 8'h41; pushed[3] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            ID_call = 1'b1;
            ID_pc = (i == 0) ? 8'h20 : (i == 1) ? 8'h30 : (i == 2) ? 8'h40 : 8'hFF;
            tick();
            chk("fill_push", ID_push, 1);
            chk("fill_spc", stack_pc, pushed[i]);
            ID_call = 1'b0;
            tick();
        end
        chk("fill_depth", depth, 4);   chk("fill_full", full, 1);
        chk("fill_spc_wrap", stack_pc, 8'h00);

        ID_call = 1'b1; ID_pc = 8'h50;
        tick();
        chk("ovf_push", ID_push, 0);   chk("ovf_flag", overflow, 1);
        chk("ovf_depth", depth, 4);    chk("ovf_stall", stall, 0);
        chk("ovf_spc", stack_pc, 8'h00);
        ID_call = 1'b0;
        tick();

        // Drain in LIFO order; upper rd1 bits must be ignored
        for (int i = 3; i >= 0; i--) begin
            ID_ret = 1'b1; ID_rd1 = {24'hABCD_EF, pushed[i]};
            tick();
            chk("drain_pop", ID_pop, 1);
            ID_ret = 1'b0;
            tick(); tick();
            chk("drain_rv", ret_valid, 1);
            chk("drain_rpc", ret_pc, pushed[i]);
            tick();
        end
        chk("drain_depth", depth, 0);  chk("drain_empty", empty, 1);
        chk("drain_ovf_sticky", overflow, 1);

        // RET on empty stack
        ID_ret = 1'b1;
        tick();
        chk("udf_pop", ID_pop, 0);     chk("udf_flag", underflow, 1);
        chk("udf_stall", stall, 0);
        ID_ret = 1'b0;
        tick();
        chk("udf_rv1", ret_valid, 0);
        tick();
        chk("udf_rv2", ret_valid, 0);  chk("udf_depth", depth, 0);

        // CALL and RET together with depth 1
        ID_call = 1'b1; ID_pc = 8'h60;
        tick();
        ID_call = 1'b0;
        tick();
        chk("col_pre_depth", depth, 1); chk("col_pre_flag", collision, 0);
        ID_call = 1'b1; ID_ret = 1'b1; ID_pc = 8'h05;
        tick();
        chk("col_push", ID_push, 1);   chk("col_pop", ID_pop, 0);
        chk("col_spc", stack_pc, 8'h06); chk("col_depth", depth, 2);
        chk("col_flag", collision, 1);
        ID_call = 1'b0; ID_ret = 1'b0;
        tick();
        chk("col_pop_after", ID_pop, 0); chk("col_stall_after", stall, 0);

        // CALL held during a RET stall is taken only once back in IDLE
        ID_ret = 1'b1; ID_rd1 = 32'h0000_0006;
        tick();
        chk("hold_pop", ID_pop, 1);
        ID_ret = 1'b0; ID_call = 1'b1; ID_pc = 8'h70;
        tick();
        chk("hold_push_e1", ID_push, 0);
        tick();
        chk("hold_rv", ret_valid, 1);  chk("hold_push_e2", ID_push, 0);
        chk("hold_rpc", ret_pc, 8'h06);
        tick();
        chk("hold_push_e3", ID_push, 0); chk("hold_stall_e3", stall, 0);
        chk("hold_depth_e3", depth, 1);
        tick();
        chk("hold_push_e4", ID_push, 1); chk("hold_spc", stack_pc, 8'h71);
        chk("hold_depth_e4", depth, 2);
        ID_call = 1'b0;
        tick();

        // Asynchronous reset while in POP_WAIT
        ID_ret = 1'b1; ID_rd1 = 32'h0000_0099;
        tick();
        ID_ret = 1'b0;
        tick();
        chk("mid_stall", stall, 1);
        #2 reset = 1'b0;
        #1;
        chk("mid_pop", ID_pop, 0);     chk("mid_stall_rst", stall, 0);
        chk("mid_depth", depth, 0);    chk("mid_rv", ret_valid, 0);
        chk("mid_ovf", overflow, 0);   chk("mid_col", collision, 0);
        chk("mid_empty", empty, 1);
        tick();
        reset = 1'b1;
        tick();
        chk("post_rv1", ret_valid, 0); chk("post_stall", stall, 0);
        tick();
        chk("post_rv2", ret_valid, 0); chk("post_rpc", ret_pc, 0);
        chk("post_depth", depth, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
